// File: rtl/parking_occupancy_tracker.sv
// Slot occupancy tracker with debounced sensors, reservation count and entry gate FSM.
// Optional reservation expiry is built when PARK_TIMEOUT_EN is defined.
module parking_occupancy_tracker #(
   parameter int NUM_SLOTS       = 8,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int GATE_CLOSE_CYC  = 3,
   parameter int TIMEOUT_CYCLES  = 256,
   parameter int CNT_W           = $clog2(NUM_SLOTS + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_SLOTS-1:0] slot_raw,
   input  logic                 entry_req,
   input  logic                 car_passed,
   output logic [NUM_SLOTS-1:0] occupied,
   output logic [CNT_W-1:0]     free_count,
   output logic [CNT_W-1:0]     pending_count,
   output logic [CNT_W-1:0]     avail_count,
   output logic                 is_full,
   output logic                 is_empty,
   output logic                 entry_grant,
   output logic                 gate_open
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int CL_W = $clog2(GATE_CLOSE_CYC + 1);
   localparam int SW   = CNT_W + 2;

   typedef enum logic [1:0] {IDLE, OPEN, CLOSE} gate_state_e;

   logic [NUM_SLOTS-1:0] sync1_q, sync2_q;
   logic [NUM_SLOTS-1:0] occ_q, occ_d, occ_prev_q;
   logic [DB_W-1:0]      db_q [NUM_SLOTS];
   logic [DB_W-1:0]      db_d [NUM_SLOTS];
   logic [CNT_W-1:0]     fills, occ_pop;
   logic [CNT_W-1:0]     free_q, free_d;
   logic [CNT_W-1:0]     pending_q, pending_d;
   logic [CNT_W-1:0]     avail_q, avail_d;
   logic                 is_full_q, is_full_d;
   logic                 is_empty_q, is_empty_d;
   logic [SW-1:0]        p_inc, p_dec, p_diff;
   logic                 expire;

   gate_state_e          state_q;
   logic [CL_W-1:0]      close_q;
   logic                 gate_open_q, entry_grant_q;

   always_comb begin
      occ_d = occ_q;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         db_d[i] = '0;
         if (sync2_q[i] != occ_q[i]) begin
            if (db_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) occ_d[i] = ~occ_q[i];
            else db_d[i] = db_q[i] + 1'b1;
         end
      end
   end

   // Fills are taken from the registered occupancy edge so they line up with free_count.
   always_comb begin
      fills   = '0;
      occ_pop = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         fills   = fills + CNT_W'(occ_q[i] & ~occ_prev_q[i]);
         occ_pop = occ_pop + CNT_W'(occ_q[i]);
      end
   end

`ifdef PARK_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] to_q, to_d;

   always_comb begin
      to_d   = '0;
      expire = 1'b0;
      if (pending_q != '0 && fills == '0) begin
         if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) expire = 1'b1;
         else to_d = to_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) to_q <= '0;
      else        to_q <= to_d;
   end
`else
   assign expire = 1'b0;
`endif

   always_comb begin
      free_d     = CNT_W'(NUM_SLOTS) - occ_pop;
      is_empty_d = (occ_q == '0);
      p_inc      = SW'(pending_q) + SW'(entry_grant_q);
      p_dec      = SW'(fills) + SW'(expire);
      p_diff     = '0;
      pending_d  = '0;
      if (p_dec < p_inc) begin
         p_diff    = p_inc - p_dec;
         pending_d = (p_diff > SW'(NUM_SLOTS)) ? CNT_W'(NUM_SLOTS)
                                               : p_diff[CNT_W-1:0];
      end
      avail_d   = (free_d > pending_d) ? free_d - pending_d : '0;
      is_full_d = (avail_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         occ_q      <= '0;
         occ_prev_q <= '0;
         for (int i = 0; i < NUM_SLOTS; i++) db_q[i] <= '0;
         free_q     <= CNT_W'(NUM_SLOTS);
         pending_q  <= '0;
         avail_q    <= CNT_W'(NUM_SLOTS);
         is_full_q  <= 1'b0;
         is_empty_q <= 1'b1;
      end else begin
         sync1_q    <= slot_raw;
         sync2_q    <= sync1_q;
         occ_q      <= occ_d;
         occ_prev_q <= occ_q;
         for (int i = 0; i < NUM_SLOTS; i++) db_q[i] <= db_d[i];
         free_q     <= free_d;
         pending_q  <= pending_d;
         avail_q    <= avail_d;
         is_full_q  <= is_full_d;
         is_empty_q <= is_empty_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         close_q       <= '0;
         gate_open_q   <= 1'b0;
         entry_grant_q <= 1'b0;
      end else begin
         entry_grant_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (entry_req && avail_q != '0) begin
                  state_q       <= OPEN;
                  gate_open_q   <= 1'b1;
                  entry_grant_q <= 1'b1;
               end
            end
            OPEN: begin
               if (car_passed) begin
                  state_q     <= CLOSE;
                  gate_open_q <= 1'b0;
                  close_q     <= '0;
               end
            end
            CLOSE: begin
               if (close_q == CL_W'(GATE_CLOSE_CYC - 1)) state_q <= IDLE;
               else close_q <= close_q + 1'b1;
            end
            default: begin
               state_q     <= IDLE;
               gate_open_q <= 1'b0;
            end
         endcase
      end
   end

   assign occupied      = occ_q;
   assign free_count    = free_q;
   assign pending_count = pending_q;
   assign avail_count   = avail_q;
   assign is_full       = is_full_q;
   assign is_empty      = is_empty_q;
   assign entry_grant   = entry_grant_q;
   assign gate_open     = gate_open_q;

endmodule

// File: tb/tb_parking_occupancy_tracker.sv
// Bench for parking_occupancy_tracker: directed scenarios plus a cycle model.
// Build with PARK_TIMEOUT_EN defined to exercise reservation expiry.
module tb_parking_occupancy_tracker;

   localparam int N  = 8;
   localparam int DB = 4;
   localparam int GC = 3;
   localparam int TO = 16;

   logic       clk, rst_n;
   logic [7:0] slot_raw;
   logic       entry_req, car_passed;
   logic [7:0] occupied;
   logic [3:0] free_count, pending_count, avail_count;
   logic       is_full, is_empty, entry_grant, gate_open;

   int n_checks = 0;
   int n_fail   = 0;

   parking_occupancy_tracker #(
      .NUM_SLOTS(N), .DEBOUNCE_CYCLES(DB),
      .GATE_CLOSE_CYC(GC), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .slot_raw(slot_raw),
      .entry_req(entry_req), .car_passed(car_passed),
      .occupied(occupied), .free_count(free_count),
      .pending_count(pending_count), .avail_count(avail_count),
      .is_full(is_full), .is_empty(is_empty),
      .entry_grant(entry_grant), .gate_open(gate_open)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: hist[j] is the raw sample from j+1 edges ago.
   logic [7:0] hist [DB+1];
   logic [7:0] m_occ, m_occ_prev;
   int m_free, m_pend, m_avail, m_to, m_close_left;
   bit m_full, m_empty, m_grant, m_gate;

   always @(posedge clk or negedge rst_n) begin : mdl
      logic [7:0] nocc;
      int fills, p, nfree, expire;
      bit all_diff;
      if (!rst_n) begin
         for (int j = 0; j <= DB; j++) hist[j] = '0;
         m_occ = '0; m_occ_prev = '0;
         m_free = N; m_pend = 0; m_avail = N; m_to = 0;
         m_full = 0; m_empty = 1; m_grant = 0; m_gate = 0;
         m_close_left = 0;
      end else begin
         // a slot flips once the last DB synchronised samples all disagree
         nocc = m_occ;
         for (int i = 0; i < N; i++) begin
            all_diff = 1;
            for (int j = 1; j <= DB; j++)
               if (hist[j][i] == m_occ[i]) all_diff = 0;
            if (all_diff) nocc[i] = ~m_occ[i];
         end
         for (int j = DB; j > 0; j--) hist[j] = hist[j-1];
         hist[0] = slot_raw;

         fills = $countones(m_occ & ~m_occ_prev);
         nfree = N - $countones(m_occ);
         expire = 0;
`ifdef PARK_TIMEOUT_EN
         if (m_pend > 0 && fills == 0) begin
            m_to++;
            if (m_to == TO) begin expire = 1; m_to = 0; end
         end else m_to = 0;
`endif
         p = m_pend + (m_grant ? 1 : 0) - fills - expire;
         if (p < 0) p = 0;
         if (p > N) p = N;

         m_grant = 0;
         if (m_gate) begin
            if (car_passed) begin m_gate = 0; m_close_left = GC; end
         end else if (m_close_left > 0) m_close_left--;
         else if (entry_req && m_avail > 0) begin m_gate = 1; m_grant = 1; end

         m_empty    = (m_occ == 0);
         m_occ_prev = m_occ;
         m_occ      = nocc;
         m_free     = nfree;
         m_pend     = p;
         m_avail    = (nfree > p) ? nfree - p : 0;
         m_full     = (m_avail == 0);
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("m_occupied", occupied, m_occ);
         chk("m_free", free_count, m_free);
         chk("m_pending", pending_count, m_pend);
         chk("m_avail", avail_count, m_avail);
         chk("m_full", is_full, m_full);
         chk("m_empty", is_empty, m_empty);
         chk("m_grant", entry_grant, m_grant);
         chk("m_gate", gate_open, m_gate);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst_n = 0; slot_raw = '0; entry_req = 0; car_passed = 0;
      tick(3);
      #2 rst_n = 1;

      // reset state
      tick(2);
      chk("rst_free", free_count, 8);
      chk("rst_empty", is_empty, 1);
      chk("rst_full", is_full, 0);
      chk("rst_gate", gate_open, 0);
      chk("rst_avail", avail_count, 8);
      chk("rst_occ", occupied, 0);

      // debounce latency and glitch rejection
      slot_raw = 8'h04;
      tick(5);
      chk("db_early", occupied[2], 0);
      tick(1);
      chk("db_6clk", occupied[2], 1);
      chk("db_free_lag", free_count, 8);
      tick(1);
      chk("db_free", free_count, 7);
      slot_raw = 8'h24;
      tick(3);
      slot_raw = 8'h04;
      tick(10);
      chk("glitch", occupied[5], 0);

      // grant / pass handshake
      entry_req = 1;
      tick(1);
      chk("g1_grant", entry_grant, 1);
      chk("g1_gate", gate_open, 1);
      tick(1);
      chk("g1_pulse", entry_grant, 0);
      chk("g1_pend", pending_count, 1);
      chk("g1_avail", avail_count, 6);
      entry_req = 0;
      tick(2);
      chk("open_hold", gate_open, 1);
      car_passed = 1; entry_req = 1;
      tick(1);
      car_passed = 0;
      chk("close0", gate_open, 0);
      for (int i = 1; i <= 3; i++) begin
         tick(1);
         chk("close_n", gate_open, 0);
      end
      tick(1);
      chk("regrant_gate", gate_open, 1);
      chk("regrant", entry_grant, 1);
      entry_req = 0; car_passed = 1;
      tick(1);
      car_passed = 0;
      tick(6);
      chk("pend2", pending_count, 2);
      chk("avail5", avail_count, 5);

      // lot full with one reservation
      slot_raw = 8'h7F;
      tick(8);
      chk("f_occ", occupied, 8'h7F);
      chk("f_free", free_count, 1);
      chk("f_pend_sat", pending_count, 0);
      chk("f_avail", avail_count, 1);
      entry_req = 1;
      tick(1);
      chk("f_grant", entry_grant, 1);
      tick(1);
      chk("f_pend", pending_count, 1);
      chk("f_avail0", avail_count, 0);
      chk("f_full", is_full, 1);
      car_passed = 1;
      tick(1);
      car_passed = 0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         chk("full_block", gate_open, 0);
      end
      slot_raw = 8'h7E;
      for (int i = 1; i <= 7; i++) begin
         tick(1);
         chk("wait_free", gate_open, 0);
      end
      tick(1);
      chk("unblock_grant", entry_grant, 1);
      chk("unblock_gate", gate_open, 1);
      entry_req = 0;
      tick(1);
      chk("ub_pend", pending_count, 2);
      chk("ub_full", is_full, 1);
      car_passed = 1;
      tick(1);
      car_passed = 0;
      tick(5);

      // grant and fill in the same cycle
      slot_raw = 8'h0F;
      tick(10);
      chk("c_free", free_count, 4);
      chk("c_pend", pending_count, 1);
      chk("c_avail", avail_count, 3);
      slot_raw = 8'h1F;
      tick(5);
      entry_req = 1;
      tick(1);
      chk("c_grant", entry_grant, 1);
      chk("c_fill", occupied[4], 1);
      entry_req = 0;
      tick(1);
      chk("cancel_pend", pending_count, 1);
      chk("cancel_free", free_count, 3);
      chk("cancel_avail", avail_count, 2);
      car_passed = 1;
      tick(1);
      car_passed = 0;
      tick(5);
      slot_raw = 8'h3F;
      tick(8);
      chk("park_pend0", pending_count, 0);
      slot_raw = 8'h7F;
      tick(8);
      chk("nogrant_pend", pending_count, 0);
      chk("nogrant_free", free_count, 1);
      chk("nogrant_avail", avail_count, 1);

      // reset while the gate is open
      entry_req = 1;
      tick(1);
      chk("mr_gate", gate_open, 1);
      #3 rst_n = 0;
      #1;
      chk("mr_gate0", gate_open, 0);
      chk("mr_occ", occupied, 0);
      chk("mr_free", free_count, 8);
      chk("mr_pend", pending_count, 0);
      chk("mr_empty", is_empty, 1);
      slot_raw = '0; entry_req = 0;
      tick(1);
      #2 rst_n = 1;
      tick(1);

      // reservation expiry
      entry_req = 1;
      tick(1);
      chk("t_grant1", entry_grant, 1);
      car_passed = 1;
      tick(1);
      car_passed = 0;
      tick(4);
      chk("t_grant2", entry_grant, 1);
      entry_req = 0; car_passed = 1;
      tick(1);
      car_passed = 0;
      chk("t_pend2", pending_count, 2);
      tick(10);
      chk("t_pend_a16", pending_count, 2);
      tick(1);
`ifdef PARK_TIMEOUT_EN
      chk("t_pend_a17", pending_count, 1);
`else
      chk("t_pend_a17", pending_count, 2);
`endif
      tick(16);
`ifdef PARK_TIMEOUT_EN
      chk("t_pend_a33", pending_count, 0);
`else
      chk("t_pend_a33", pending_count, 2);
`endif
      tick(2);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
